// File: rtl/la_capture_if.sv
// la_capture_if: readout stream of the capture buffer (valid/ready)
interface la_capture_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] rd_data;
  logic rd_valid;
  logic rd_ready;
  modport master (output rd_data, rd_valid, input rd_ready);
  modport slave (input rd_data, rd_valid, output rd_ready);
endinterface

// File: rtl/la_capture.sv
// la_capture: triggered pre/post window capture of a probe bus with valid/ready readout
module la_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int ADDR_W = 8,
  parameter int PRE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH-1:0] probe_i,
  input  logic sample_en_i,
  input  logic arm_i,
  input  logic [WIDTH-1:0] trig_value_i,
  input  logic [WIDTH-1:0] trig_mask_i,
  output logic busy_o,
  output logic triggered_o,
  output logic done_o,
  la_capture_if.master rd
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_LOAD, S_DUMP} state_e;
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE - 1);
  localparam logic [CW-1:0] POST_N = CW'(DEPTH - PRE);
  localparam logic [CW-1:0] LAST_N = CW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PRE_A = ADDR_W'(PRE);
  logic [WIDTH-1:0] mem [DEPTH];
  state_e state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, trig_ptr_q, trig_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d, trig_q, trig_d, done_q, done_d;
  logic wr_en, hit;
  assign wr_en = sample_en_i && (state_q inside {S_PRE, S_WAIT, S_POST});
  assign hit = ((probe_i ^ trig_value_i) & trig_mask_i) == '0;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr_q] <= probe_i;
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    trig_ptr_d = trig_ptr_q;
    cnt_d = cnt_q;
    rd_data_d = rd_data_q;
    rd_valid_d = rd_valid_q;
    trig_d = trig_q;
    done_d = done_q;
    case (state_q)
      S_IDLE: if (arm_i) begin
        state_d = S_PRE;
        wr_ptr_d = '0;
        cnt_d = '0;
        trig_d = 1'b0;
        done_d = 1'b0;
      end
      S_PRE: if (wr_en) begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == PRE_LAST ? S_WAIT : S_PRE;
      end
      S_WAIT: if (wr_en && hit) begin
        trig_ptr_d = wr_ptr_q;
        trig_d = 1'b1;
        cnt_d = CW'(1);
        state_d = POST_N == CW'(1) ? S_LOAD : S_POST;
      end
      S_POST: if (wr_en) begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q + 1'b1 == POST_N ? S_LOAD : S_POST;
      end
      S_LOAD: begin
        rd_data_d = mem[trig_ptr_q - PRE_A];
        rd_ptr_d = trig_ptr_q - PRE_A + 1'b1;
        cnt_d = '0;
        rd_valid_d = 1'b1;
        state_d = S_DUMP;
      end
      S_DUMP: if (rd.rd_ready) begin
        // rd_ptr already points at the following word, so a transfer refills without a bubble
        cnt_d = cnt_q + 1'b1;
        rd_data_d = cnt_q == LAST_N ? rd_data_q : mem[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + 1'b1;
        rd_valid_d = cnt_q != LAST_N;
        done_d = cnt_q == LAST_N;
        state_d = cnt_q == LAST_N ? S_IDLE : S_DUMP;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      trig_ptr_q <= '0;
      cnt_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      trig_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      cnt_q <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      trig_q <= trig_d;
      done_q <= done_d;
    end
  assign busy_o = state_q != S_IDLE;
  assign triggered_o = trig_q;
  assign done_o = done_q;
  assign rd.rd_data = rd_data_q;
  assign rd.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_la_capture.sv
// tb_la_capture: directed and random capture runs checked against a sample-history window model
module tb_la_capture;
  localparam int W = 8;
  localparam int D = 16;
  localparam int A = 4;
  localparam int P = 4;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] probe = 8'h00;
  logic [7:0] tv = 8'h00;
  logic [7:0] tm = 8'h00;
  logic sen = 1'b0;
  logic arm = 1'b0;
  logic busy, trg, done;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] hist[$];
  logic [7:0] exp_q[$];
  logic [7:0] f, l;
  always #5 clk = ~clk;
  la_capture_if #(.WIDTH(W)) rd();
  la_capture #(.WIDTH(W), .DEPTH(D), .ADDR_W(A), .PRE(P)) dut (
    .clk(clk), .rst(rst), .probe_i(probe), .sample_en_i(sen), .arm_i(arm),
    .trig_value_i(tv), .trig_mask_i(tm), .busy_o(busy), .triggered_o(trg),
    .done_o(done), .rd(rd.master)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  // one clock: inputs applied before the edge, probe counter advances 1 time unit after it
  task automatic cyc(input bit s, input bit a);
    sen = s;
    arm = a;
    @(posedge clk);
    if (s) hist.push_back(probe);
    #1;
    probe = probe + 8'd1;
  endtask
  function automatic bit sen_of(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return probe % 3 == 0;
    return $urandom_range(3, 0) != 0;
  endfunction
  task automatic run(input logic [7:0] v, input logic [7:0] m, input int smode, input int rmode,
                     input bit glitch, output logic [7:0] first, output logic [7:0] last);
    int n, k, hit;
    bit seen, a, r, stall;
    logic [7:0] held;
    first = 8'h00;
    last = 8'h00;
    tv = v;
    tm = m;
    cyc(sen_of(smode), 1'b1);
    hist.delete();
    chk("busy_after_arm", busy, 1);
    chk("trig_clear_after_arm", trg, 0);
    chk("done_clear_after_arm", done, 0);
    n = 0;
    seen = 1'b0;
    while (!rd.rd_valid && n < 4000) begin
      a = glitch && trg && !seen;
      if (trg) seen = 1'b1;
      cyc(sen_of(smode), a);
      n++;
    end
    chk("readout_start_timeout", n < 4000, 1);
    hit = -1;
    for (int i = P; i < hist.size(); i++)
      if (((hist[i] ^ v) & m) == 8'h00) begin
        hit = i;
        break;
      end
    exp_q.delete();
    if (hit >= 0 && hit - P + D <= hist.size())
      for (int j = 0; j < D; j++) exp_q.push_back(hist[hit - P + j]);
    chk("window_available", exp_q.size(), D);
    chk("triggered", trg, 1);
    k = 0;
    n = 0;
    while (k < D && n < 2000) begin
      r = rmode == 0 ? 1'b1 : rmode == 1 ? (n % 3 == 0) : 1'($urandom_range(1, 0));
      rd.rd_ready = r;
      a = glitch && n == 2;
      if (rd.rd_valid && r) begin
        chk($sformatf("word%0d", k), rd.rd_data, k < exp_q.size() ? 32'(exp_q[k]) : 'x);
        if (k == 0) first = rd.rd_data;
        if (k == D - 1) last = rd.rd_data;
        k++;
      end
      stall = rd.rd_valid && !r;
      held = rd.rd_data;
      cyc(1'($urandom_range(1, 0)), a);
      n++;
      if (stall) begin
        chk("stall_hold", rd.rd_data, held);
        chk("stall_valid", rd.rd_valid, 1);
      end
    end
    chk("word_count", k, D);
    chk("valid_low_end", rd.rd_valid, 0);
    chk("done_end", done, 1);
    chk("busy_end", busy, 0);
    chk("trig_held_end", trg, 1);
    rd.rd_ready = 1'b0;
  endtask
  initial begin
    int n;
    rst = 1'b1;
    rd.rd_ready = 1'b0;
    repeat (2) cyc(1'b1, 1'b1);
    chk("rst_rd_data", rd.rd_data, 0);
    chk("rst_rd_valid", rd.rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_triggered", trg, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    cyc(1'b1, 1'b0);
    chk("idle_ignores_sample_en", busy, 0);
    probe = 8'hFF;
    run(8'h20, 8'hFF, 0, 0, 1'b0, f, l);
    chk("c1_first", f, 8'h1C);
    chk("c1_last", l, 8'h2B);
    probe = 8'hFF;
    run(8'h20, 8'h00, 0, 0, 1'b0, f, l);
    chk("c2_first", f, 8'h00);
    chk("c2_last", l, 8'h0F);
    probe = 8'hFF;
    run(8'h20, 8'hFF, 0, 1, 1'b0, f, l);
    chk("c3_first", f, 8'h1C);
    chk("c3_last", l, 8'h2B);
    probe = 8'hFF;
    run(8'h30, 8'hFF, 1, 0, 1'b0, f, l);
    chk("c4_first", f, 8'h24);
    chk("c4_last", l, 8'h51);
    probe = 8'hFF;
    run(8'h20, 8'hFF, 0, 0, 1'b1, f, l);
    chk("c5_first", f, 8'h1C);
    chk("c5_last", l, 8'h2B);
    probe = 8'hFF;
    tv = 8'h20;
    tm = 8'hFF;
    cyc(1'b1, 1'b1);
    n = 0;
    while (!trg && n < 200) begin
      cyc(1'b1, 1'b0);
      n++;
    end
    chk("c6_reach_post", trg, 1);
    #3 rst = 1'b1;
    #1;
    chk("c6_async_busy", busy, 0);
    chk("c6_async_trig", trg, 0);
    chk("c6_async_valid", rd.rd_valid, 0);
    repeat (2) cyc(1'b1, 1'b0);
    rst = 1'b0;
    probe = 8'hFF;
    run(8'h20, 8'hFF, 0, 0, 1'b0, f, l);
    chk("c6_first", f, 8'h1C);
    chk("c6_last", l, 8'h2B);
    for (int t = 0; t < 4; t++) begin
      probe = 8'($urandom);
      run(8'($urandom), 8'($urandom) & 8'h3F, 2, 2, 1'($urandom_range(1, 0)), f, l);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
